// File: rtl/vscale_htif_pcr_responder_if.sv
// HTIF PCR request/response channel between the host (master) and the target-side responder (slave).
interface vscale_htif_pcr_responder_if #(
    parameter int PCR_WIDTH  = 64,
    parameter int ADDR_WIDTH = 12
);
    logic                  htif_pcr_req_valid;
    logic                  htif_pcr_req_ready;
    logic                  htif_pcr_req_rw;
    logic [ADDR_WIDTH-1:0] htif_pcr_req_addr;
    logic [PCR_WIDTH-1:0]  htif_pcr_req_data;
    logic                  htif_pcr_resp_valid;
    logic                  htif_pcr_resp_ready;
    logic [PCR_WIDTH-1:0]  htif_pcr_resp_data;

    modport master (
        output htif_pcr_req_valid,
        input  htif_pcr_req_ready,
        output htif_pcr_req_rw,
        output htif_pcr_req_addr,
        output htif_pcr_req_data,
        input  htif_pcr_resp_valid,
        output htif_pcr_resp_ready,
        input  htif_pcr_resp_data
    );

    modport slave (
        input  htif_pcr_req_valid,
        output htif_pcr_req_ready,
        input  htif_pcr_req_rw,
        input  htif_pcr_req_addr,
        input  htif_pcr_req_data,
        output htif_pcr_resp_valid,
        input  htif_pcr_resp_ready,
        output htif_pcr_resp_data
    );
endinterface

// File: rtl/vscale_htif_pcr_responder.sv
// Target-side HTIF PCR endpoint: one outstanding request, one response, and the
// tohost/fromhost mailbox registers shared with the core.
module vscale_htif_pcr_responder #(
    parameter int                    PCR_WIDTH      = 64,
    parameter int                    ADDR_WIDTH     = 12,
    parameter logic [ADDR_WIDTH-1:0] TO_HOST_ADDR   = 12'h780,
    parameter logic [ADDR_WIDTH-1:0] FROM_HOST_ADDR = 12'h781
) (
    input  logic                   clk,
    input  logic                   reset,
    vscale_htif_pcr_responder_if.slave htif,
    input  logic                   core_tohost_wen,
    input  logic [PCR_WIDTH-1:0]   core_tohost_wdata,
    output logic [PCR_WIDTH-1:0]   core_fromhost,
    input  logic                   core_fromhost_clr,
    output logic                   tohost_nonzero
);

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    logic                  req_valid;
    logic                  req_rw;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [PCR_WIDTH-1:0]  req_data;
    logic                  resp_ready;
    logic                  req_ready;
    logic                  resp_valid;

    logic                  accept;
    logic                  resp_done;
    logic                  hit_tohost;
    logic                  hit_fromhost;

    logic [PCR_WIDTH-1:0]  tohost_q;
    logic [PCR_WIDTH-1:0]  tohost_d;
    logic [PCR_WIDTH-1:0]  fromhost_q;
    logic [PCR_WIDTH-1:0]  fromhost_d;
    logic [PCR_WIDTH-1:0]  resp_data_p0;
    logic [PCR_WIDTH-1:0]  resp_data_d;
    logic [PCR_WIDTH-1:0]  read_value;

    assign req_valid  = htif.htif_pcr_req_valid;
    assign req_rw     = htif.htif_pcr_req_rw;
    assign req_addr   = htif.htif_pcr_req_addr;
    assign req_data   = htif.htif_pcr_req_data;
    assign resp_ready = htif.htif_pcr_resp_ready;

    assign accept       = req_valid && req_ready;
    assign resp_done    = resp_valid && resp_ready;
    assign hit_tohost   = (req_addr == TO_HOST_ADDR);
    assign hit_fromhost = (req_addr == FROM_HOST_ADDR);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)    state_d = RESP;
            RESP:    if (resp_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Ready is masked while reset is held so no request is ever seen as accepted in reset.
    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state_q)
            IDLE:    req_ready  = reset;
            RESP:    resp_valid = 1'b1;
            default: begin
                req_ready  = 1'b0;
                resp_valid = 1'b0;
            end
        endcase
    end

    // Both reads and swap-writes return the value held before the accept edge.
    always_comb begin
        read_value = '0;
        if (hit_tohost) begin
            read_value = tohost_q;
        end else if (hit_fromhost) begin
            read_value = fromhost_q;
        end
    end

    always_comb begin
        resp_data_d = resp_data_p0;
        if (accept) begin
            resp_data_d = read_value;
        end
    end

    // Core tohost write is applied last so it beats both the read-clear and a host write.
    always_comb begin
        tohost_d = tohost_q;
        if (accept && hit_tohost) begin
            tohost_d = req_rw ? req_data : '0;
        end
        if (core_tohost_wen) begin
            tohost_d = core_tohost_wdata;
        end
    end

    // Host fromhost write is applied last so it beats a simultaneous core clear.
    always_comb begin
        fromhost_d = fromhost_q;
        if (core_fromhost_clr) begin
            fromhost_d = '0;
        end
        if (accept && hit_fromhost && req_rw) begin
            fromhost_d = req_data;
        end
    end

    // ---- stage p0: response data and mailbox registers ----
    always_ff @(posedge clk) begin
        if (!reset) begin
            tohost_q     <= '0;
            fromhost_q   <= '0;
            resp_data_p0 <= '0;
        end else begin
            tohost_q     <= tohost_d;
            fromhost_q   <= fromhost_d;
            resp_data_p0 <= resp_data_d;
        end
    end

    assign htif.htif_pcr_req_ready  = req_ready;
    assign htif.htif_pcr_resp_valid = resp_valid;
    assign htif.htif_pcr_resp_data  = resp_data_p0;

    assign core_fromhost  = fromhost_q;
    assign tohost_nonzero = |tohost_q;

endmodule
